muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit beside the core's single-cycle ALU, executing all eight M-extension ops (funct3 000–111). Accepts one request at a time over a valid/ready handshake, iterates one bit per cycle through a shared shift/add-subtract datapath, applies sign correction, and holds the result until the pipeline takes it. The execute stage stalls on `busy` and flushes in-flight work on branch mispredict/trap.

---
 rtl/muldiv_pkg.sv | 57 +++++
 rtl/muldiv_datapath.sv | 128 ++++++++++++
 rtl/muldiv_unit.sv | 108 ++++++++++
 tb/tb_muldiv_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative RV32M multiply/divide unit.
//   - funct3 op encodings (MD_MUL .. MD_REMU)
//   - FSM state encoding (MD_IDLE, MD_CALC, MD_FIX, MD_DONE)
//   - iteration count and small operand-classification helpers
package muldiv_pkg;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_CALC = 2'b01,
        MD_FIX  = 2'b10,
        MD_DONE = 2'b11
    } md_state_e;

    localparam int         MD_ITERS     = 32;
    localparam logic [4:0] MD_LAST_ITER = 5'(MD_ITERS - 1);

    // rs1 is interpreted as signed for MULH, MULHSU, DIV, REM.
    function automatic logic md_rs1_signed(input logic [2:0] f);
        return (f == MD_MULH) || (f == MD_MULHSU) || (f == MD_DIV) || (f == MD_REM);
    endfunction

    // rs2 is interpreted as signed for MULH, DIV, REM.
    function automatic logic md_rs2_signed(input logic [2:0] f);
        return (f == MD_MULH) || (f == MD_DIV) || (f == MD_REM);
    endfunction

    // Magnitude of a value; only negated when it is signed-interpreted and negative.
    function automatic logic [31:0] md_abs(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (32'd0 - v) : v;
    endfunction

    // The single signed-division case whose true quotient does not fit in 32 bits.
    function automatic logic md_is_ovf(input logic [2:0] f, input logic [31:0] a,
                                       input logic [31:0] b);
        return ((f == MD_DIV) || (f == MD_REM)) &&
               (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    endfunction

    // Ops whose result is known without iterating.
    function automatic logic md_early_out(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        logic is_div;
        is_div = f[2];
        return (is_div && (b == 32'd0)) || md_is_ovf(f, a, b) ||
               (!is_div && ((a == 32'd0) || (b == 32'd0)));
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: operand/accumulator registers and the shared shift-add /
// restoring-subtract step for the RV32M unit, plus final sign correction.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   load_i          capture op and operand magnitudes, clear accumulators
//   step_i          perform one multiply or divide iteration
//   fix_i           apply sign fix / special cases, register result
//   funct3_i        RV32M op of the request being loaded
//   rs1_i, rs2_i    raw request operands
//   result_o        registered result (held until the next fix_i or reset)
module muldiv_datapath
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        step_i,
    input  logic        fix_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    output logic [31:0] result_o
);

    // a_q: multiplicand / divisor magnitude.
    // b_q: multiplier (shifted right) / dividend shifted out MSB-first while
    //      quotient bits shift in at the LSB, so it ends holding the quotient.
    logic [2:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [63:0] acc_q;
    logic [31:0] rem_q;
    logic        neg_q;
    logic        rem_neg_q;
    logic        div0_q;
    logic        ovf_q;
    logic [31:0] rs1_q;
    logic [31:0] result_q;

    logic [32:0] mul_sum_s;
    logic [32:0] rem_shift_s;
    logic        q_bit_s;
    logic [63:0] acc_d;
    logic [31:0] b_d;
    logic [31:0] rem_d;
    logic [63:0] prod_s;
    logic [31:0] quo_s;
    logic [31:0] remv_s;
    logic [31:0] result_d;
    logic        s1_neg_s;
    logic        s2_neg_s;

    assign s1_neg_s = md_rs1_signed(funct3_i) && rs1_i[31];
    assign s2_neg_s = md_rs2_signed(funct3_i) && rs2_i[31];

    // One iteration: right-shifting shift-add for multiply, restoring step for divide.
    always_comb begin
        mul_sum_s   = {1'b0, acc_q[63:32]} + (b_q[0] ? {1'b0, a_q} : 33'd0);
        // 33-bit partial remainder: previous remainder with next dividend bit appended.
        rem_shift_s = {rem_q, b_q[31]};
        q_bit_s     = (rem_shift_s >= {1'b0, a_q});
        acc_d       = acc_q;
        b_d         = b_q;
        rem_d       = rem_q;
        if (op_q[2]) begin
            // When the trial subtract succeeds the difference is below the
            // divisor, so a 32-bit wrap-around subtract is exact.
            rem_d = q_bit_s ? (rem_shift_s[31:0] - a_q) : rem_shift_s[31:0];
            b_d   = {b_q[30:0], q_bit_s};
        end else begin
            acc_d = {mul_sum_s, acc_q[31:1]};
            b_d   = {1'b0, b_q[31:1]};
        end
    end

    // Sign correction, word selection and special-case override.
    always_comb begin
        prod_s = neg_q     ? (64'd0 - acc_q) : acc_q;
        quo_s  = neg_q     ? (32'd0 - b_q)   : b_q;
        remv_s = rem_neg_q ? (32'd0 - rem_q) : rem_q;
        case (op_q)
            MD_MUL:                       result_d = prod_s[31:0];
            MD_MULH, MD_MULHSU, MD_MULHU: result_d = prod_s[63:32];
            MD_DIV, MD_DIVU:              result_d = div0_q ? 32'hFFFF_FFFF :
                                                     (ovf_q ? 32'h8000_0000 : quo_s);
            MD_REM, MD_REMU:              result_d = div0_q ? rs1_q :
                                                     (ovf_q ? 32'h0000_0000 : remv_s);
            default:                      result_d = 32'h0000_0000;
        endcase
    end

    // Operand capture, iteration and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= 3'b000;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            acc_q     <= 64'd0;
            rem_q     <= 32'd0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
            ovf_q     <= 1'b0;
            rs1_q     <= 32'd0;
            result_q  <= 32'd0;
        end else if (load_i) begin
            op_q      <= funct3_i;
            a_q       <= md_abs(rs2_i, md_rs2_signed(funct3_i));
            b_q       <= md_abs(rs1_i, md_rs1_signed(funct3_i));
            acc_q     <= 64'd0;
            rem_q     <= 32'd0;
            neg_q     <= s1_neg_s ^ s2_neg_s;
            rem_neg_q <= s1_neg_s;
            div0_q    <= funct3_i[2] && (rs2_i == 32'd0);
            ovf_q     <= md_is_ovf(funct3_i, rs1_i, rs2_i);
            rs1_q     <= rs1_i;
        end else if (step_i) begin
            acc_q <= acc_d;
            b_q   <= b_d;
            rem_q <= rem_d;
        end else if (fix_i) begin
            result_q <= result_d;
        end
    end

    assign result_o = result_q;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit (all eight funct3 ops).
// One request at a time; one bit per cycle through muldiv_datapath.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   flush                     kill in-flight op, no response produced
//   req_valid/req_ready       request handshake; funct3, rs1, rs2 captured on accept
//   resp_valid/resp_ready     response handshake; resp_data held while resp_valid
//   busy                      high in CALC, FIX, DONE
// Configuration macro: MULDIV_EARLY_OUT_EN -- divide-by-zero, signed overflow
// and multiply by zero skip CALC (2-cycle latency instead of 34).
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            busy
);

    md_state_e  state_q;
    logic [4:0] cnt_q;
    logic       resp_valid_q;

    logic load_s;
    logic step_s;
    logic fix_s;
    logic early_s;

`ifdef MULDIV_EARLY_OUT_EN
    assign early_s = md_early_out(req_funct3, req_rs1, req_rs2);
`else
    assign early_s = 1'b0;
`endif

    assign req_ready = (state_q == MD_IDLE) && !rst && !flush;
    assign load_s    = req_valid && req_ready;
    // A flush in FIX must not disturb the previously returned resp_data.
    assign step_s    = (state_q == MD_CALC) && !flush;
    assign fix_s     = (state_q == MD_FIX) && !flush;

    // Control FSM: state, iteration counter and response-valid flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= MD_IDLE;
            cnt_q        <= 5'd0;
            resp_valid_q <= 1'b0;
        end else if (flush) begin
            state_q      <= MD_IDLE;
            cnt_q        <= 5'd0;
            resp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (load_s) begin
                        cnt_q   <= 5'd0;
                        state_q <= early_s ? MD_FIX : MD_CALC;
                    end
                end
                MD_CALC: begin
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == MD_LAST_ITER) begin
                        state_q <= MD_FIX;
                    end
                end
                MD_FIX: begin
                    state_q      <= MD_DONE;
                    resp_valid_q <= 1'b1;
                end
                MD_DONE: begin
                    if (resp_ready) begin
                        state_q      <= MD_IDLE;
                        resp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= MD_IDLE;
                    resp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    muldiv_datapath u_datapath (
        .clk      (clk),
        .rst      (rst),
        .load_i   (load_s),
        .step_i   (step_s),
        .fix_i    (fix_s),
        .funct3_i (req_funct3),
        .rs1_i    (req_rs1),
        .rs2_i    (req_rs2),
        .result_o (resp_data)
    );

    assign resp_valid = resp_valid_q;
    assign busy       = (state_q != MD_IDLE);

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        early;
        string       name;
    } vec_t;

    vec_t vq[$];

    muldiv_unit #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_funct3 (req_funct3),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add_vec(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input logic early, input string name);
        vec_t v;
        v.f = f; v.a = a; v.b = b; v.exp = exp; v.early = early; v.name = name;
        vq.push_back(v);
    endtask

    function automatic int exp_lat(input logic early);
`ifdef MULDIV_EARLY_OUT_EN
        return early ? 2 : 34;
`else
        return (early && 1'b0) ? 2 : 34;
`endif
    endfunction

    // Called at posedge+1 with the unit idle. Returns result and latency
    // (edges from the accepting edge up to the one after which resp_valid rises).
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
        req_funct3 = f; req_rs1 = a; req_rs2 = b; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
        res = resp_data;
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] res;
        int          lat;
        int          saw;

        add_vec(MD_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, "mul_7x-3");
        add_vec(MD_MULH,   32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, "mulh_7x-3");
        add_vec(MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, "mulhu_max");
        add_vec(MD_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, "mulhsu_-1x2");
        add_vec(MD_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, "mulh_min_sq");
        add_vec(MD_MUL,    32'h0000_0000, 32'h0000_1234, 32'h0000_0000, 1'b1, "mul_zero");
        add_vec(MD_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0, "div_-7/2");
        add_vec(MD_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, "rem_-7/2");
        add_vec(MD_DIVU,   32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 1'b0, "divu_max/16");
        add_vec(MD_REMU,   32'd100,       32'd7,         32'd2,         1'b0, "remu_100/7");
        add_vec(MD_DIV,    32'hFFFF_FFEC, 32'hFFFF_FFFD, 32'h0000_0006, 1'b0, "div_-20/-3");
        add_vec(MD_REM,    32'hFFFF_FFEC, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 1'b0, "rem_-20/-3");
        add_vec(MD_DIV,    32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, "div_7/-2");
        add_vec(MD_REM,    32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "rem_7/-2");
        add_vec(MD_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1, "div_by0");
        add_vec(MD_REM,    32'd5,         32'd0,         32'd5,         1'b1, "rem_by0");
        add_vec(MD_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1, "divu_by0");
        add_vec(MD_REMU,   32'h1234_5678, 32'd0,         32'h1234_5678, 1'b1, "remu_by0");
        add_vec(MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "div_ovf");
        add_vec(MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, "rem_ovf");

        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        req_funct3 = 3'b000; req_rs1 = 32'd0; req_rs2 = 32'd0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready",  {31'd0, req_ready},  32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_busy",       {31'd0, busy},       32'd0);
        chk("rst_resp_data",  resp_data,           32'd0);
        rst = 1'b0;
        #1 chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Table-driven vectors
        foreach (vq[i]) begin
            chk({vq[i].name, "_ready"}, {31'd0, req_ready}, 32'd1);
            do_op(vq[i].f, vq[i].a, vq[i].b, res, lat);
            chk({vq[i].name, "_data"}, res, vq[i].exp);
            chk({vq[i].name, "_lat"}, lat, exp_lat(vq[i].early));
        end

        // Hold result with resp_ready low for 10 cycles
        req_funct3 = MD_DIVU; req_rs1 = 32'd100; req_rs2 = 32'd7; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
        chk("hold_lat", lat, 32'd34);
        for (int k = 0; k < 10; k++) begin
            chk("hold_valid", {31'd0, resp_valid}, 32'd1);
            chk("hold_data",  resp_data,           32'd14);
            chk("hold_ready", {31'd0, req_ready},  32'd0);
            @(posedge clk);
            #1;
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        chk("post_hs_req_ready",  {31'd0, req_ready},  32'd1);
        chk("post_hs_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("post_hs_data_kept",  resp_data,           32'd14);

        // Flush at CALC cycle 15
        req_funct3 = MD_MUL; req_rs1 = 32'd3; req_rs2 = 32'd5; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("flush_busy_before", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_busy",       {31'd0, busy},       32'd0);
        chk("flush_resp_valid", {31'd0, resp_valid}, 32'd0);
        saw = 0;
        for (int k = 0; k < 40; k++) begin
            if (resp_valid) saw++;
            @(posedge clk);
            #1;
        end
        chk("flush_no_resp", saw, 32'd0);
        chk("flush_data_kept", resp_data, 32'd14);

        // Flush coincident with a request drops it
        req_funct3 = MD_DIVU; req_rs1 = 32'd8; req_rs2 = 32'd2; req_valid = 1'b1; flush = 1'b1;
        #1 chk("flush_req_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1 req_valid = 1'b0; flush = 1'b0;
        chk("flush_req_dropped", {31'd0, busy}, 32'd0);

        do_op(MD_DIVU, 32'd9, 32'd3, res, lat);
        chk("after_flush_data", res, 32'd3);
        chk("after_flush_lat",  lat, 32'd34);

        // Reset at CALC cycle 20
        req_funct3 = MD_DIV; req_rs1 = 32'd100; req_rs2 = 32'd3; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("midrst_busy",       {31'd0, busy},       32'd0);
        chk("midrst_resp_data",  resp_data,           32'd0);
        chk("midrst_req_ready",  {31'd0, req_ready},  32'd0);
        rst = 1'b0;
        #1 chk("rst_release_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        do_op(MD_REMU, 32'd100, 32'd7, res, lat);
        chk("after_rst_data", res, 32'd2);
        chk("after_rst_lat",  lat, 32'd34);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
